// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven operand/operator sequencer for the signed two-digit BCD calculator ALU.
module calc_sequencer #(
  parameter int         MAX_DIGITS = 2,
  parameter logic [2:0] OP_ADD     = 3'b001,
  parameter logic [2:0] OP_SUB     = 3'b010
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       key_strobe,
  input  logic [3:0] key_code,
  input  logic [8:0] alu_result,
  output logic [8:0] alu_op1,
  output logic [8:0] alu_op2,
  output logic [2:0] alu_opcode,
  output logic [8:0] display,
  output logic       busy,
  output logic       result_valid
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, EXEC, RESULT} state_t;
  state_t state_q, state_d;
  logic [8:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d, pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic chain_q, chain_d, rv_q, rv_d;
  logic is_dig, is_op, is_eq, is_neg, is_clr, room;
  logic [2:0] new_op;
  logic [8:0] edit, entered, negated;
  assign is_dig  = key_strobe && key_code <= 4'd9;
  assign is_op   = key_strobe && (key_code == 4'hA || key_code == 4'hB);
  assign is_eq   = key_strobe && key_code == 4'hC;
  assign is_clr  = key_strobe && key_code == 4'hD;
  assign is_neg  = key_strobe && key_code == 4'hE;
  assign new_op  = key_code == 4'hB ? OP_SUB : OP_ADD;
  assign room    = cnt_q < CW'(MAX_DIGITS);
  assign edit    = state_q == ENTRY_B ? b_q : a_q;
  assign entered = {edit[8], edit[3:0], key_code};
  // zero magnitude never carries a sign
  assign negated = edit[7:0] != 8'd0 ? {~edit[8], edit[7:0]} : edit;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    chain_d = chain_q;
    rv_d    = 1'b0;
    case (state_q)
      ENTRY_A: begin
        if (is_dig && room) begin
          a_d   = entered;
          cnt_d = cnt_q + 1'b1;
        end
        if (is_neg) a_d = negated;
        if (is_op) begin
          op_d    = new_op;
          b_d     = 9'd0;
          cnt_d   = '0;
          state_d = ENTRY_B;
        end
      end
      ENTRY_B: begin
        if (is_dig && room) begin
          b_d   = entered;
          cnt_d = cnt_q + 1'b1;
        end
        if (is_neg) b_d = negated;
        if (is_op && cnt_q == '0) op_d = new_op;
        if (is_op && cnt_q != '0) begin
          pend_d  = new_op;
          chain_d = 1'b1;
          state_d = EXEC;
        end
        if (is_eq && cnt_q != '0) begin
          chain_d = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        a_d     = alu_result;
        rv_d    = 1'b1;
        chain_d = 1'b0;
        state_d = chain_q ? ENTRY_B : RESULT;
        if (chain_q) begin
          op_d  = pend_q;
          b_d   = 9'd0;
          cnt_d = '0;
        end
      end
      default: begin
        if (is_dig) begin
          a_d     = {5'd0, key_code};
          cnt_d   = CW'(1);
          state_d = ENTRY_A;
        end
        if (is_op) begin
          op_d    = new_op;
          b_d     = 9'd0;
          cnt_d   = '0;
          state_d = ENTRY_B;
        end
        if (is_eq) state_d = EXEC;
        if (is_neg) a_d = negated;
      end
    endcase
    if (is_clr) begin
      state_d = ENTRY_A;
      a_d     = 9'd0;
      b_d     = 9'd0;
      op_d    = OP_ADD;
      pend_d  = OP_ADD;
      cnt_d   = '0;
      chain_d = 1'b0;
      rv_d    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= ENTRY_A;
      a_q     <= 9'd0;
      b_q     <= 9'd0;
      op_q    <= OP_ADD;
      pend_q  <= OP_ADD;
      cnt_q   <= '0;
      chain_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      rv_q    <= rv_d;
    end
  end
  assign alu_op1      = a_q;
  assign alu_op2      = b_q;
  assign alu_opcode   = op_q;
  assign display      = state_q == ENTRY_B && cnt_q != '0 ? b_q : a_q;
  assign busy         = state_q == EXEC;
  assign result_valid = rv_q;
endmodule
